uart_tx: RTL and testbench

- 8N1 UART transmitter: serialises one byte per request as 1 start bit (0), 8 data bits LSB-first, 1 stop bit (1).
- Bit period is set at run time by a clock-cycle divider input, e.g. 868 cycles at 100 MHz gives 115200 baud.
- Sits between a byte-producing controller (start/done handshake) and the serial TX pin.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_baud_timer.sv | 40 ++++
 rtl/uart_tx.sv | 106 ++++++++++
 tb/tb_uart_tx.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART transmitter.
// Also provides the divider helper used by the bit timer.
package uart_pkg;

    localparam int DATA_BITS  = 8;
    localparam int BAUD_DIV_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    // Terminal timer count for a divider; a divider of 0 behaves like 1.
    function automatic logic [BAUD_DIV_W-1:0] last_count(input logic [BAUD_DIV_W-1:0] div);
        return (div == '0) ? '0 : div - BAUD_DIV_W'(1);
    endfunction

endpackage

// File: rtl/uart_baud_timer.sv
// Bit-period timer: counts 0..N-1 while enabled and strobes bit_end_o on the
// final cycle of each bit period.
module uart_baud_timer
    import uart_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  en_i,
    input  logic [BAUD_DIV_W-1:0] div_i,
    output logic                  bit_end_o
);

    logic [BAUD_DIV_W-1:0] count_q;
    logic [BAUD_DIV_W-1:0] count_d;
    logic                  at_last;

    assign at_last   = (count_q == last_count(div_i));
    assign bit_end_o = en_i && at_last;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = at_last ? '0 : count_q + BAUD_DIV_W'(1);
        end
    end

    // NOTE: reset is synchronous, so it lives inside the clocked block and is
    // only seen on a rising edge; no asynchronous sensitivity is needed.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: start bit, 8 data bits LSB-first, stop bit, with a
// run-time bit-period divider captured at the start of each frame.
module uart_tx
    import uart_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_BITS-1:0]  din_i,
    input  logic [BAUD_DIV_W-1:0] baud_div,
    input  logic                  tx_start_i,
    output logic                  tx_o,
    output logic                  tx_done_tick_o
);

    uart_state_e           state_q, state_d;
    logic [BAUD_DIV_W-1:0] div_q, div_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic [2:0]            bitcntr, bitcntr_d;
    logic                  tx_q, tx_d;
    logic                  bit_end;

    uart_baud_timer u_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (state_q == IDLE),
        .en_i      (state_q != IDLE),
        .div_i     (div_q),
        .bit_end_o (bit_end)
    );

    // NOTE: every output of this block gets a default first so that no
    // path through the case statement can infer a latch.
    always_comb begin
        state_d        = state_q;
        div_d          = div_q;
        shift_d        = shift_q;
        bitcntr_d      = bitcntr;
        tx_d           = tx_q;
        tx_done_tick_o = 1'b0;

        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (tx_start_i) begin
                    shift_d = din_i;
                    div_d   = baud_div;
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    bitcntr_d = '0;
                    tx_d      = shift_q[0];
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    // tx_d anticipates the next bit so tx_o stays a plain register.
                    if (bitcntr == 3'(DATA_BITS - 1)) begin
                        bitcntr_d = '0;
                        tx_d      = 1'b1;
                        state_d   = STOP;
                    end else begin
                        bitcntr_d = bitcntr + 3'd1;
                        tx_d      = shift_q[1];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    tx_done_tick_o = 1'b1;
                    tx_d           = 1'b1;
                    state_d        = IDLE;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            div_q   <= '0;
            shift_q <= '0;
            bitcntr <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            shift_q <= shift_d;
            bitcntr <= bitcntr_d;
            tx_q    <= tx_d;
        end
    end

    assign tx_o = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: compares the serial line, done tick and
// bitcntr against a per-frame model built from the 8N1 frame layout.
module tb_uart_tx;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [7:0]  din_i;
    logic [15:0] baud_div;
    logic        tx_start_i;
    logic        tx_o;
    logic        tx_done_tick_o;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk_i = ~clk_i;

    uart_tx dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .din_i          (din_i),
        .baud_div       (baud_div),
        .tx_start_i     (tx_start_i),
        .tx_o           (tx_o),
        .tx_done_tick_o (tx_done_tick_o)
    );

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Line level for bit slot idx of a frame: 0 = start, 1..8 = data LSB-first, 9 = stop.
    function automatic logic model_bit(input logic [7:0] d, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx-1];
        return 1'b1;
    endfunction

    // Requests one frame and follows it for its full 10*N cycles. Returns in
    // the first idle cycle after the stop bit.
    task automatic run_frame(input string name, input logic [7:0] d,
                             input logic [15:0] div, input bit disturb);
        int n, len, err_tx, err_bc, done_cnt, done_pos;
        logic [7:0] rec;
        n        = (div == 16'd0) ? 1 : int'(div);
        len      = 10 * n;
        err_tx   = 0;
        err_bc   = 0;
        done_cnt = 0;
        done_pos = -1;
        rec      = 8'h00;
        din_i      = d;
        baud_div   = div;
        tx_start_i = 1'b1;
        tick();
        tx_start_i = 1'b0;
        for (int k = 0; k < len; k++) begin
            int   slot;
            logic [2:0] want_bc;
            slot    = k / n;
            want_bc = (slot >= 1 && slot <= 8) ? 3'(slot - 1) : 3'd0;
            if (tx_o !== model_bit(d, slot)) err_tx++;
            if (dut.bitcntr !== want_bc) err_bc++;
            if (slot >= 1 && slot <= 8 && (k % n) == n / 2) rec[dut.bitcntr] = tx_o;
            if (tx_done_tick_o === 1'b1) begin
                done_cnt++;
                done_pos = k;
            end
            if (disturb && k == len / 2) begin
                din_i      = ~d;
                baud_div   = 16'($urandom_range(1, 50));
                tx_start_i = 1'b1;
            end
            if (disturb && k == len / 2 + 1) tx_start_i = 1'b0;
            tick();
        end

        tests_run++;
        if (err_tx !== 0) begin
            tests_failed++;
            $display("FAIL %s tx_line: %0d cycles differ from model, want 0", name, err_tx);
        end
        tests_run++;
        if (err_bc !== 0) begin
            tests_failed++;
            $display("FAIL %s bitcntr: %0d cycles differ from model, want 0", name, err_bc);
        end
        tests_run++;
        if (done_cnt !== 1) begin
            tests_failed++;
            $display("FAIL %s done_count: got %0d, want 1", name, done_cnt);
        end
        tests_run++;
        if (done_pos !== len - 1) begin
            tests_failed++;
            $display("FAIL %s done_cycle: got %0d, want %0d", name, done_pos, len - 1);
        end
        tests_run++;
        if (rec !== d) begin
            tests_failed++;
            $display("FAIL %s rebuilt_byte: got %02h, want %02h", name, rec, d);
        end
    endtask

    // Watches an idle line for a number of cycles: tx high, no done tick.
    task automatic expect_idle(input string name, input int cycles);
        int bad;
        bad = 0;
        for (int k = 0; k < cycles; k++) begin
            if (tx_o !== 1'b1 || tx_done_tick_o !== 1'b0) bad++;
            tick();
        end
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL %s idle_line: %0d bad cycles, want 0", name, bad);
        end
    endtask

    task automatic test_reset();
        rst_i      = 1'b1;
        tx_start_i = 1'b0;
        din_i      = 8'h00;
        baud_div   = 16'd0;
        tick();
        tick();
        tests_run++;
        if (tx_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset tx_o: got %b, want 1", tx_o);
        end
        tests_run++;
        if (tx_done_tick_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset done: got %b, want 0", tx_done_tick_o);
        end
        tests_run++;
        if (dut.bitcntr !== 3'd0) begin
            tests_failed++;
            $display("FAIL reset bitcntr: got %0d, want 0", dut.bitcntr);
        end
        rst_i = 1'b0;
        expect_idle("reset", 20);
    endtask

    task automatic test_basic();
        run_frame("aa_868", 8'hAA, 16'd868, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_frame("b2b_cc", 8'hCC, 16'($urandom_range(1, 12)), 1'b0);
        for (int i = 0; i < 5; i++) begin
            run_frame($sformatf("b2b_rand%0d", i), 8'($urandom_range(0, 255)),
                      16'($urandom_range(1, 12)), 1'b0);
        end
        expect_idle("b2b_tail", 8);
    endtask

    task automatic test_mid_frame();
        run_frame("mid_frame", 8'($urandom_range(0, 255)), 16'd20, 1'b1);
        expect_idle("mid_frame", 65);
    endtask

    task automatic test_small_div();
        run_frame("div1", 8'h5A, 16'd1, 1'b0);
        run_frame("div0", 8'h5A, 16'd0, 1'b0);
        expect_idle("small_div", 5);
    endtask

    task automatic test_reset_mid_frame();
        din_i      = 8'($urandom_range(0, 255));
        baud_div   = 16'd4;
        tx_start_i = 1'b1;
        tick();
        tx_start_i = 1'b0;
        // Start bit is cycles 0..3; data bit 3 occupies cycles 16..19.
        for (int k = 0; k < 17; k++) tick();
        tests_run++;
        if (dut.bitcntr !== 3'd3) begin
            tests_failed++;
            $display("FAIL rst_mid position: bitcntr %0d, want 3", dut.bitcntr);
        end
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        tests_run++;
        if (tx_o !== 1'b1 || tx_done_tick_o !== 1'b0 || dut.bitcntr !== 3'd0) begin
            tests_failed++;
            $display("FAIL rst_mid abort: tx=%b done=%b bitcntr=%0d, want 1 0 0",
                     tx_o, tx_done_tick_o, dut.bitcntr);
        end
        expect_idle("rst_mid", 50);
        run_frame("after_rst", 8'($urandom_range(0, 255)), 16'd3, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_mid_frame();
        test_small_div();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
